i2s_tx_master: RTL and testbench
================================

Name: i2s_tx_master

Overview:
- I2S master transmitter for the audio sampler, clocked directly by the 12.288 MHz PLL master clock.
- Divides the master clock into BCLK and LRCLK.
- Accepts stereo sample pairs through a valid/ready handshake and serialises them in standard I2S format: 1-BCLK delay, MSB first, left channel while LRCLK is low.
- Gated by the PLL lock flag, so no audio clocks toggle until the master clock is stable.

Parameters:
- DATA_W, 24: sample width per channel, 1..SLOT_W-1.
- SLOT_W, 32: BCLKs per channel slot. Frame length = 2*SLOT_W BCLKs.
- MCLK_DIV, 4: master-clock cycles per BCLK, even, >=2. Defaults give 64 BCLK/frame at 48 kHz.
- LOCK_WAIT, 16: consecutive cycles pll_locked must be high before transmission starts.

Ports:
- refclk  in  1  master clock (PLL outclk_0, 12.288 MHz)
- rst  in  1  synchronous active-high reset
- pll_locked  in  1  PLL lock flag, already synchronous to refclk
- s_valid  in  1  sample pair valid
- s_ready  out  1  holding register empty
- s_left  in  DATA_W  left sample, two's complement
- s_right  in  DATA_W  right sample, two's complement
- bclk  out  1  bit clock
- lrclk  out  1  word select, 0 = left
- sdata  out  1  serial data
- frame_start  out  1  one-cycle pulse when a frame is loaded
- underrun  out  1  one-cycle pulse when a frame is loaded with no sample available

Behaviour:
- Reset values: all outputs 0 except s_ready = 1. State IDLE, counters 0, holding register empty.
- States:
  - IDLE: counters held at 0; bclk/lrclk/sdata = 0. A lock counter increments while pll_locked = 1 and clears when it is 0. When the count reaches LOCK_WAIT, go to RUN.
  - RUN: normal operation, described below.
- pll_locked = 0 in RUN: next cycle returns to IDLE. bclk, lrclk, sdata, div_cnt, bit_cnt and the lock counter go to 0; the holding register is cleared. Any partial frame is abandoned.
- div_cnt counts 0..MCLK_DIV-1 and wraps. bclk register = 1 while div_cnt >= MCLK_DIV/2, else 0. bclk is low in the first RUN cycle.
- bit_cnt counts 0..2*SLOT_W-1 and advances when div_cnt wraps to 0. Shift-out events occur on cycles where div_cnt == 0 (bclk falling edge), so data is stable on the rising edge.
- Per bit slot b, with p = b mod SLOT_W:
  - lrclk = (b >= SLOT_W)
  - sdata = 0 at p == 0 (I2S delay bit)
  - sdata = sample bit [DATA_W-p] for 1 <= p <= DATA_W
  - sdata = 0 for p > DATA_W
- Frame load occurs at div_cnt == 0 and bit_cnt == 0, including the first RUN cycle:
  - Holding register full: its left/right are copied into shift registers, the holding register empties, and frame_start pulses.
  - Holding register empty: shift registers are loaded with 0; frame_start and underrun both pulse.
- Handshake:
  - s_ready = !hold_full; transfer on s_valid && s_ready. s_ready deasserts the cycle after a transfer.
  - No bypass: a transfer coinciding with an empty-register frame load fills the holding register for the next frame; the current frame is still an underrun.
  - s_ready may be high in IDLE, and a sample may be accepted before lock.
  - Accepting a new pair and consuming the held pair in the same cycle cannot occur, because s_ready = 0 when full.
- Latency: a sample accepted at least 1 cycle before a frame load appears starting at that frame's p = 1 BCLK. Frame period = 2*SLOT_W*MCLK_DIV refclk cycles (256 at defaults).
- rst asserted mid-frame: next edge restores reset values, regardless of pll_locked.

Optional Feature:
- Macro: I2S_TX_HOLD_LAST_EN.
- Defined: on underrun, the shift registers reload the last successfully transmitted pair instead of zeros (0 if none since reset or IDLE). underrun still pulses.
- Undefined: underrun frames carry zeros.

Test Plan:
- Reset then pll_locked = 1 held: lrclk stays 0 for LOCK_WAIT (16) + 1 cycles. frame_start then pulses every 256 cycles. bclk period = 4 cycles, high 2. lrclk toggles every 128 cycles.
- s_left = 0xABCDEF, s_right = 0x123456 accepted before first frame:
  - Left slot: sdata = 0, then bits 1010_1011_1100_1101_1110_1111, then 7 zeros.
  - Right slot: 0, then 0x123456 bits MSB first, then zeros.
  - Each bit changes only when bclk falls.
- No s_valid for a frame: underrun pulses coincident with frame_start and sdata = 0 for all 64 bits. With I2S_TX_HOLD_LAST_EN, the previous 0xABCDEF/0x123456 repeats instead.
- s_valid held high continuously: exactly one transfer per 256 cycles. s_ready is low from the cycle after acceptance until the cycle after the next frame load.
- pll_locked dropped at bit_cnt = 40: bclk, lrclk, sdata are 0 the next cycle and s_ready = 1. Relock: 16 cycles then a fresh frame from bit 0.
- rst pulsed for 1 cycle mid-right-slot: all outputs return to reset values the next cycle. A restart requires LOCK_WAIT again.

Source files
------------

// File: rtl/i2s_tx_master.sv
// I2S master transmitter: divides refclk into BCLK/LRCLK and serialises stereo pairs (MSB first, 1-BCLK delay).
// Optional build macro I2S_TX_HOLD_LAST_EN: on underrun repeat the last transmitted pair instead of zeros.
`timescale 1ns/1ps
module i2s_tx_master #(
  parameter int DATA_W    = 24,
  parameter int SLOT_W    = 32,
  parameter int MCLK_DIV  = 4,
  parameter int LOCK_WAIT = 16
) (
  input  logic              refclk,
  input  logic              rst,
  input  logic              pll_locked,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_left,
  input  logic [DATA_W-1:0] s_right,
  output logic              bclk,
  output logic              lrclk,
  output logic              sdata,
  output logic              frame_start,
  output logic              underrun
);

  localparam int DIV_W  = $clog2(MCLK_DIV);
  localparam int BIT_W  = $clog2(2 * SLOT_W);
  localparam int LOCK_W = $clog2(LOCK_WAIT + 1);

  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(MCLK_DIV - 1);
  localparam logic [DIV_W-1:0]  DIV_HALF = DIV_W'(MCLK_DIV / 2);
  localparam logic [BIT_W-1:0]  BIT_LAST = BIT_W'(2 * SLOT_W - 1);
  localparam logic [BIT_W-1:0]  SLOT_B   = BIT_W'(SLOT_W);
  localparam logic [LOCK_W-1:0] LOCK_B   = LOCK_W'(LOCK_WAIT);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t              state, state_n;
  logic [LOCK_W-1:0]   lock_cnt, lock_n;
  logic [DIV_W-1:0]    div_cnt, div_n;
  logic [BIT_W-1:0]    bit_cnt, bit_n;
  logic                hold_full, hold_full_n;
  logic [DATA_W-1:0]   hold_left, hold_left_n;
  logic [DATA_W-1:0]   hold_right, hold_right_n;
  logic [DATA_W-1:0]   frame_left, frame_left_n;
  logic [DATA_W-1:0]   frame_right, frame_right_n;
`ifdef I2S_TX_HOLD_LAST_EN
  logic [DATA_W-1:0]   last_left, last_left_n;
  logic [DATA_W-1:0]   last_right, last_right_n;
`endif
  logic                frame_start_n, underrun_n;
  logic                bclk_n, lrclk_n, sdata_n;
  logic [BIT_W-1:0]    slot_pos;
  logic [DATA_W-1:0]   word_sel;

  assign s_ready = !hold_full;

  // Sequencing, handshake and frame load; everything here is the next value of a register.
  always_comb begin
    state_n       = state;
    lock_n        = lock_cnt;
    div_n         = div_cnt;
    bit_n         = bit_cnt;
    hold_full_n   = hold_full;
    hold_left_n   = hold_left;
    hold_right_n  = hold_right;
    frame_left_n  = frame_left;
    frame_right_n = frame_right;
`ifdef I2S_TX_HOLD_LAST_EN
    last_left_n   = last_left;
    last_right_n  = last_right;
`endif
    frame_start_n = 1'b0;
    underrun_n    = 1'b0;

    if (s_valid && !hold_full) begin
      hold_full_n  = 1'b1;
      hold_left_n  = s_left;
      hold_right_n = s_right;
    end

    case (state)
      IDLE: begin
        div_n = '0;
        bit_n = '0;
`ifdef I2S_TX_HOLD_LAST_EN
        last_left_n  = '0;
        last_right_n = '0;
`endif
        if (!pll_locked) begin
          lock_n = '0;
        end else if (lock_cnt == LOCK_B) begin
          state_n = RUN;
          lock_n  = '0;
        end else begin
          lock_n = lock_cnt + 1'b1;
        end
      end

      RUN: begin
        if (!pll_locked) begin
          // Lock lost: abandon the frame and drop any queued pair.
          state_n     = IDLE;
          lock_n      = '0;
          div_n       = '0;
          bit_n       = '0;
          hold_full_n = 1'b0;
        end else begin
          if (div_cnt == DIV_LAST) begin
            div_n = '0;
            bit_n = (bit_cnt == BIT_LAST) ? '0 : bit_cnt + 1'b1;
          end else begin
            div_n = div_cnt + 1'b1;
          end

          if (div_cnt == '0 && bit_cnt == '0) begin
            frame_start_n = 1'b1;
            if (hold_full) begin
              frame_left_n  = hold_left;
              frame_right_n = hold_right;
              hold_full_n   = 1'b0;
`ifdef I2S_TX_HOLD_LAST_EN
              last_left_n   = hold_left;
              last_right_n  = hold_right;
`endif
            end else begin
              underrun_n = 1'b1;
`ifdef I2S_TX_HOLD_LAST_EN
              frame_left_n  = last_left;
              frame_right_n = last_right;
`else
              frame_left_n  = '0;
              frame_right_n = '0;
`endif
            end
          end
        end
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Audio pin values for the coming cycle, decoded from next counter values so the pins are registered.
  always_comb begin
    slot_pos = (bit_n >= SLOT_B) ? bit_n - SLOT_B : bit_n;
    word_sel = (bit_n >= SLOT_B) ? frame_right_n : frame_left_n;
    bclk_n   = 1'b0;
    lrclk_n  = 1'b0;
    sdata_n  = 1'b0;
    if (state_n == RUN) begin
      bclk_n  = (div_n >= DIV_HALF);
      lrclk_n = (bit_n >= SLOT_B);
      for (int i = 0; i < DATA_W; i++) begin
        if (int'(slot_pos) == DATA_W - i) begin
          sdata_n = word_sel[i];
        end
      end
    end
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      state       <= IDLE;
      lock_cnt    <= '0;
      div_cnt     <= '0;
      bit_cnt     <= '0;
      hold_full   <= 1'b0;
      hold_left   <= '0;
      hold_right  <= '0;
      frame_left  <= '0;
      frame_right <= '0;
`ifdef I2S_TX_HOLD_LAST_EN
      last_left   <= '0;
      last_right  <= '0;
`endif
      bclk        <= 1'b0;
      lrclk       <= 1'b0;
      sdata       <= 1'b0;
      frame_start <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      state       <= state_n;
      lock_cnt    <= lock_n;
      div_cnt     <= div_n;
      bit_cnt     <= bit_n;
      hold_full   <= hold_full_n;
      hold_left   <= hold_left_n;
      hold_right  <= hold_right_n;
      frame_left  <= frame_left_n;
      frame_right <= frame_right_n;
`ifdef I2S_TX_HOLD_LAST_EN
      last_left   <= last_left_n;
      last_right  <= last_right_n;
`endif
      bclk        <= bclk_n;
      lrclk       <= lrclk_n;
      sdata       <= sdata_n;
      frame_start <= frame_start_n;
      underrun    <= underrun_n;
    end
  end

endmodule

// File: tb/tb_i2s_tx_master.sv
// Directed self-checking bench for i2s_tx_master at default parameters (256 refclk per frame).
// Expected data on underrun frames follows I2S_TX_HOLD_LAST_EN when that macro is defined.
`timescale 1ns/1ps
module tb_i2s_tx_master;

  logic        refclk = 1'b0;
  logic        rst;
  logic        pll_locked;
  logic        s_valid;
  logic        s_ready;
  logic [23:0] s_left;
  logic [23:0] s_right;
  logic        bclk;
  logic        lrclk;
  logic        sdata;
  logic        frame_start;
  logic        underrun;
  logic [4:0]  outs;

  int errors = 0;
  int checks = 0;

`ifdef I2S_TX_HOLD_LAST_EN
  localparam logic [23:0] UND_L = 24'hABCDEF;
  localparam logic [23:0] UND_R = 24'h123456;
`else
  localparam logic [23:0] UND_L = 24'h000000;
  localparam logic [23:0] UND_R = 24'h000000;
`endif

  always #5 refclk = ~refclk;

  assign outs = {bclk, lrclk, sdata, frame_start, underrun};

  i2s_tx_master #(
    .DATA_W(24),
    .SLOT_W(32),
    .MCLK_DIV(4),
    .LOCK_WAIT(16)
  ) dut (
    .refclk(refclk),
    .rst(rst),
    .pll_locked(pll_locked),
    .s_valid(s_valid),
    .s_ready(s_ready),
    .s_left(s_left),
    .s_right(s_right),
    .bclk(bclk),
    .lrclk(lrclk),
    .sdata(sdata),
    .frame_start(frame_start),
    .underrun(underrun)
  );

  task automatic step();
    @(posedge refclk);
    #1;
  endtask

  // Expected {bclk, lrclk, sdata, frame_start, underrun} for refclk j (0..255) of a frame.
  function automatic logic [4:0] exp_out(int j, logic [23:0] l, logic [23:0] r, logic und);
    int b;
    int p;
    logic [23:0] w;
    logic sd;
    b  = j / 4;
    p  = b % 32;
    w  = (b < 32) ? l : r;
    sd = (p >= 1 && p <= 24) ? w[24 - p] : 1'b0;
    return {((j % 4) >= 2), (b >= 32), sd, (j == 1), ((j == 1) && und)};
  endfunction

  task automatic test_reset();
    rst        = 1'b1;
    pll_locked = 1'b0;
    s_valid    = 1'b0;
    s_left     = '0;
    s_right    = '0;
    repeat (3) step();
    checks++;
    if (outs !== 5'b0) begin
      errors++;
      $display("[TB] FAIL reset_outputs got=%b expected=%b", outs, 5'b0);
    end
    checks++;
    if (s_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_s_ready got=%b expected=1", s_ready);
    end
    pll_locked = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      checks++;
      if (outs !== 5'b0) begin
        errors++;
        $display("[TB] FAIL reset_holds_lock cyc=%0d got=%b expected=%b", i, outs, 5'b0);
      end
    end
  endtask

  task automatic test_lock_wait();
    rst     = 1'b0;
    s_valid = 1'b1;
    s_left  = 24'hABCDEF;
    s_right = 24'h123456;
    checks++;
    if (s_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL idle_s_ready got=%b expected=1", s_ready);
    end
    step();
    s_valid = 1'b0;
    checks++;
    if (s_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL idle_accept got=%b expected=0", s_ready);
    end
    for (int i = 1; i <= 16; i++) begin
      step();
      checks++;
      if (outs !== 5'b0) begin
        errors++;
        $display("[TB] FAIL lock_wait cyc=%0d got=%b expected=%b", i, outs, 5'b0);
      end
    end
  endtask

  task automatic test_frame_data();
    for (int j = 0; j < 256; j++) begin
      logic [4:0] exp;
      logic rdy;
      exp = exp_out(j, 24'hABCDEF, 24'h123456, 1'b0);
      rdy = (j >= 1);
      checks++;
      if (outs !== exp) begin
        errors++;
        $display("[TB] FAIL frame_data j=%0d got=%b expected=%b", j, outs, exp);
      end
      checks++;
      if (s_ready !== rdy) begin
        errors++;
        $display("[TB] FAIL frame_data_ready j=%0d got=%b expected=%b", j, s_ready, rdy);
      end
      step();
    end
  endtask

  task automatic test_underrun();
    for (int j = 0; j < 256; j++) begin
      logic [4:0] exp;
      exp = exp_out(j, UND_L, UND_R, 1'b1);
      checks++;
      if (outs !== exp) begin
        errors++;
        $display("[TB] FAIL underrun j=%0d got=%b expected=%b", j, outs, exp);
      end
      checks++;
      if (s_ready !== 1'b1) begin
        errors++;
        $display("[TB] FAIL underrun_ready j=%0d got=%b expected=1", j, s_ready);
      end
      step();
    end
  endtask

  task automatic test_back_to_back();
    s_valid = 1'b1;
    s_left  = 24'h800001;
    s_right = 24'h7FFFFE;
    for (int f = 0; f < 3; f++) begin
      for (int j = 0; j < 256; j++) begin
        logic [4:0] exp;
        logic rdy;
        if (f == 0) begin
          exp = exp_out(j, UND_L, UND_R, 1'b1);
          rdy = (j == 0);
        end else if (f == 1) begin
          exp = exp_out(j, 24'h800001, 24'h7FFFFE, 1'b0);
          rdy = (j == 1);
        end else begin
          exp = exp_out(j, 24'hF0F0F0, 24'h0F0F0F, 1'b0);
          rdy = (j == 1);
        end
        checks++;
        if (outs !== exp) begin
          errors++;
          $display("[TB] FAIL back_to_back f=%0d j=%0d got=%b expected=%b", f, j, outs, exp);
        end
        checks++;
        if (s_ready !== rdy) begin
          errors++;
          $display("[TB] FAIL back_to_back_ready f=%0d j=%0d got=%b expected=%b", f, j, s_ready, rdy);
        end
        if (j == 2) begin
          if (f == 0) begin
            s_left  = 24'hF0F0F0;
            s_right = 24'h0F0F0F;
          end else if (f == 1) begin
            s_left  = 24'h13579B;
            s_right = 24'h2468AC;
          end else begin
            s_valid = 1'b0;
          end
        end
        step();
      end
    end
  endtask

  task automatic test_lock_drop();
    for (int j = 0; j <= 161; j++) begin
      logic [4:0] exp;
      logic rdy;
      exp = exp_out(j, 24'h13579B, 24'h2468AC, 1'b0);
      rdy = (j >= 1 && j <= 20);
      checks++;
      if (outs !== exp) begin
        errors++;
        $display("[TB] FAIL pre_drop j=%0d got=%b expected=%b", j, outs, exp);
      end
      checks++;
      if (s_ready !== rdy) begin
        errors++;
        $display("[TB] FAIL pre_drop_ready j=%0d got=%b expected=%b", j, s_ready, rdy);
      end
      if (j == 20) begin
        s_valid = 1'b1;
        s_left  = 24'h6789AB;
        s_right = 24'hFEDCBA;
      end
      if (j == 21) s_valid = 1'b0;
      if (j == 161) pll_locked = 1'b0;
      step();
    end
    checks++;
    if (outs !== 5'b0) begin
      errors++;
      $display("[TB] FAIL lock_drop_outputs got=%b expected=%b", outs, 5'b0);
    end
    checks++;
    if (s_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL lock_drop_s_ready got=%b expected=1", s_ready);
    end
    pll_locked = 1'b1;
    for (int i = 1; i <= 17; i++) begin
      step();
      checks++;
      if (outs !== 5'b0) begin
        errors++;
        $display("[TB] FAIL relock_wait cyc=%0d got=%b expected=%b", i, outs, 5'b0);
      end
    end
    for (int j = 0; j < 256; j++) begin
      logic [4:0] exp;
      logic rdy;
      exp = exp_out(j, 24'h000000, 24'h000000, 1'b1);
      rdy = (j <= 2);
      checks++;
      if (outs !== exp) begin
        errors++;
        $display("[TB] FAIL relock_frame j=%0d got=%b expected=%b", j, outs, exp);
      end
      checks++;
      if (s_ready !== rdy) begin
        errors++;
        $display("[TB] FAIL relock_ready j=%0d got=%b expected=%b", j, s_ready, rdy);
      end
      if (j == 2) begin
        s_valid = 1'b1;
        s_left  = 24'hFFFFFF;
        s_right = 24'h000001;
      end
      if (j == 3) s_valid = 1'b0;
      step();
    end
  endtask

  task automatic test_reset_mid();
    for (int j = 0; j <= 200; j++) begin
      logic [4:0] exp;
      logic rdy;
      exp = exp_out(j, 24'hFFFFFF, 24'h000001, 1'b0);
      rdy = (j >= 1 && j <= 10);
      checks++;
      if (outs !== exp) begin
        errors++;
        $display("[TB] FAIL pre_reset j=%0d got=%b expected=%b", j, outs, exp);
      end
      checks++;
      if (s_ready !== rdy) begin
        errors++;
        $display("[TB] FAIL pre_reset_ready j=%0d got=%b expected=%b", j, s_ready, rdy);
      end
      if (j == 10) begin
        s_valid = 1'b1;
        s_left  = 24'hC3C3C3;
        s_right = 24'h3C3C3C;
      end
      if (j == 11) s_valid = 1'b0;
      if (j == 200) rst = 1'b1;
      step();
    end
    rst = 1'b0;
    checks++;
    if (outs !== 5'b0) begin
      errors++;
      $display("[TB] FAIL mid_reset_outputs got=%b expected=%b", outs, 5'b0);
    end
    checks++;
    if (s_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL mid_reset_s_ready got=%b expected=1", s_ready);
    end
    for (int i = 1; i <= 17; i++) begin
      step();
      checks++;
      if (outs !== 5'b0) begin
        errors++;
        $display("[TB] FAIL restart_wait cyc=%0d got=%b expected=%b", i, outs, 5'b0);
      end
    end
    for (int j = 0; j < 256; j++) begin
      logic [4:0] exp;
      exp = exp_out(j, 24'h000000, 24'h000000, 1'b1);
      checks++;
      if (outs !== exp) begin
        errors++;
        $display("[TB] FAIL restart_frame j=%0d got=%b expected=%b", j, outs, exp);
      end
      checks++;
      if (s_ready !== 1'b1) begin
        errors++;
        $display("[TB] FAIL restart_ready j=%0d got=%b expected=1", j, s_ready);
      end
      step();
    end
  endtask

  initial begin
    test_reset();
    test_lock_wait();
    test_frame_data();
    test_underrun();
    test_back_to_back();
    test_lock_drop();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog got=timeout expected=finish");
    $fatal(1, "[TB] simulation time limit exceeded");
  end

endmodule
